// File: rtl/button_debounce_pkg.sv
// ----------------------------------------------------------------------------
// button_pkg
//   Shared definitions for the pushbutton input path.
//   - state_t : debounce FSM state encodings
//   - DEFAULT_* : timing defaults for a 12 MHz board clock
//   - cnt_width : width of a counter that must reach (cycles - 1)
// ----------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DB_PRESS   = 2'd1,
    S_PRESSED    = 2'd2,
    S_DB_RELEASE = 2'd3
  } state_t;

  // 10 ms debounce window and 1 s long-press threshold at 12 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd120_000;
  localparam int unsigned DEFAULT_LONG_CYCLES     = 32'd12_000_000;

  // Counter width able to hold cycles-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 32'd2) ? 32'd1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a single asynchronous input bit.
//   Ports:
//     clk   : destination clock
//     rst_n : synchronous active-low reset, loads RESET_VAL into both flops
//     d     : asynchronous input
//     q     : synchronised output (two clk edges of latency)
//   Parameter RESET_VAL lets the caller pick the idle level of the pin so
//   that leaving reset does not look like an input edge.
// ----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability flop followed by the settled output flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
//   Synchronises a raw pushbutton pin, debounces it with a counter-based FSM
//   and produces a clean level, one-cycle press/release pulses, an optional
//   long-press pulse and a wrapping press counter. All outputs registered.
//
//   Ports:
//     CLK           : system clock
//     RST_N         : synchronous active-low reset
//     BTN           : raw, asynchronous, bouncing button pin
//     BTN_LEVEL     : debounced level, 1 = pressed
//     PRESS_PULSE   : one cycle on each accepted press
//     RELEASE_PULSE : one cycle on each accepted release
//     LONG_PULSE    : one cycle once per press held LONG_CYCLES after accept
//     PRESS_COUNT   : accepted presses, wraps silently
//
//   Build option: define BUTTON_LONG_PRESS_EN to include the hold counter and
//   LONG_PULSE; otherwise LONG_PULSE is constant 0 and LONG_CYCLES is unused
//   except for the parameter sanity check.
// ----------------------------------------------------------------------------
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter int unsigned ACTIVE_LOW      = 32'd1,
  parameter int unsigned COUNT_W         = 32'd8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               BTN,
  output logic               BTN_LEVEL,
  output logic               PRESS_PULSE,
  output logic               RELEASE_PULSE,
  output logic               LONG_PULSE,
  output logic [COUNT_W-1:0] PRESS_COUNT
);

  localparam logic ACTIVE_BIT = (ACTIVE_LOW != 32'd0) ? 1'b1 : 1'b0;
  localparam int unsigned DW  = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 32'd1);

  if ((DEBOUNCE_CYCLES < 32'd2) || (LONG_CYCLES <= DEBOUNCE_CYCLES)) begin : g_bad_cfg
    $error("button_debounce: DEBOUNCE_CYCLES must be >= 2 and below LONG_CYCLES");
  end

  // ---------------------------------------------------------------- sync --
  logic sync_q;
  logic p;

  // Flops reset to the released pin level so reset exit is not an edge.
  sync_2ff #(
    .RESET_VAL (ACTIVE_BIT)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (BTN),
    .q     (sync_q)
  );

  // p = 1 means pressed regardless of board polarity.
  assign p = sync_q ^ ACTIVE_BIT;

  // ----------------------------------------------------------- FSM state --
  state_t             state_r,   state_s;
  logic [DW-1:0]      dcnt_r,    dcnt_s;
  logic               level_r,   level_s;
  logic               press_r,   press_s;
  logic               release_r, release_s;
  logic [COUNT_W-1:0] count_r,   count_s;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned HW = cnt_width(LONG_CYCLES);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 32'd1);

  logic [HW-1:0] hcnt_r,  hcnt_s;
  logic          fired_r, fired_s;
  logic          long_r,  long_s;
`endif

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_s   = state_r;
    dcnt_s    = dcnt_r;
    level_s   = level_r;
    press_s   = 1'b0;
    release_s = 1'b0;
    count_s   = count_r;
`ifdef BUTTON_LONG_PRESS_EN
    hcnt_s    = hcnt_r;
    fired_s   = fired_r;
    long_s    = 1'b0;
`endif

    case (state_r)
      S_IDLE: begin
        level_s = 1'b0;
        if (p) begin
          state_s = S_DB_PRESS;
          dcnt_s  = '0;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_DB_PRESS: begin
        if (!p) begin
          state_s = S_IDLE;
        end else if (dcnt_r == D_LAST) begin
          state_s = S_PRESSED;
          press_s = 1'b1;
          level_s = 1'b1;
          count_s = count_r + COUNT_W'(1);
`ifdef BUTTON_LONG_PRESS_EN
          hcnt_s  = '0;
`endif
        end else begin
          dcnt_s = dcnt_r + DW'(1);
        end
      end

      S_PRESSED: begin
`ifdef BUTTON_LONG_PRESS_EN
        // Hold counter saturates; fired flag limits LONG_PULSE to once.
        if (hcnt_r != H_LAST) begin
          hcnt_s = hcnt_r + HW'(1);
        end else begin
          hcnt_s = hcnt_r;
        end
        if ((hcnt_r == H_LAST) && !fired_r) begin
          long_s  = 1'b1;
          fired_s = 1'b1;
        end else begin
          long_s  = 1'b0;
        end
`endif
        if (!p) begin
          state_s = S_DB_RELEASE;
          dcnt_s  = '0;
        end else begin
          state_s = S_PRESSED;
        end
      end

      S_DB_RELEASE: begin
        // A bounce back to pressed keeps hcnt and the fired flag intact.
        if (p) begin
          state_s = S_PRESSED;
        end else if (dcnt_r == D_LAST) begin
          state_s   = S_IDLE;
          release_s = 1'b1;
          level_s   = 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
          fired_s   = 1'b0;
`endif
        end else begin
          dcnt_s = dcnt_r + DW'(1);
        end
      end

      default: begin
        state_s = S_IDLE;
        level_s = 1'b0;
      end
    endcase
  end

  // State, counters and outputs; reset aborts any debounce/hold silently.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r   <= S_IDLE;
      dcnt_r    <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      count_r   <= '0;
`ifdef BUTTON_LONG_PRESS_EN
      hcnt_r    <= '0;
      fired_r   <= 1'b0;
      long_r    <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      dcnt_r    <= dcnt_s;
      level_r   <= level_s;
      press_r   <= press_s;
      release_r <= release_s;
      count_r   <= count_s;
`ifdef BUTTON_LONG_PRESS_EN
      hcnt_r    <= hcnt_s;
      fired_r   <= fired_s;
      long_r    <= long_s;
`endif
    end
  end

  assign BTN_LEVEL     = level_r;
  assign PRESS_PULSE   = press_r;
  assign RELEASE_PULSE = release_r;
  assign PRESS_COUNT   = count_r;
`ifdef BUTTON_LONG_PRESS_EN
  assign LONG_PULSE    = long_r;
`else
  assign LONG_PULSE    = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// ----------------------------------------------------------------------------
// tb_button_debounce
//   Directed bench for button_debounce with DEBOUNCE_CYCLES=8, LONG_CYCLES=32,
//   ACTIVE_LOW=1, COUNT_W=8. Inputs change 1 time unit after a rising edge;
//   outputs are sampled at that same point, so "cycle N" means the value
//   registered on the Nth rising edge after the input change.
//   Long-press expectations follow BUTTON_LONG_PRESS_EN.
// ----------------------------------------------------------------------------
module tb_button_debounce;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       BTN;
  logic       BTN_LEVEL;
  logic       PRESS_PULSE;
  logic       RELEASE_PULSE;
  logic       LONG_PULSE;
  logic [7:0] PRESS_COUNT;

  int n_cmp    = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int press_n  = 0;
  int rel_n    = 0;
  int long_n   = 0;
  int press_at = -1;
  int rel_at   = -1;
  int long_at  = -1;
  int excl_bad = 0;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int LONG_EXP_N  = 1;
  localparam int LONG_EXP_AT = 43;
`else
  localparam int LONG_EXP_N  = 0;
  localparam int LONG_EXP_AT = -1;
`endif

  button_debounce #(
    .DEBOUNCE_CYCLES (32'd8),
    .LONG_CYCLES     (32'd32),
    .ACTIVE_LOW      (32'd1),
    .COUNT_W         (32'd8)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .BTN           (BTN),
    .BTN_LEVEL     (BTN_LEVEL),
    .PRESS_PULSE   (PRESS_PULSE),
    .RELEASE_PULSE (RELEASE_PULSE),
    .LONG_PULSE    (LONG_PULSE),
    .PRESS_COUNT   (PRESS_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Restart the cycle index and pulse bookkeeping.
  task automatic mark();
    cyc = 0; press_n = 0; rel_n = 0; long_n = 0;
    press_at = -1; rel_at = -1; long_at = -1;
  endtask

  // Advance n clocks, logging pulses and exclusivity violations.
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (PRESS_PULSE === 1'b1)   begin press_n++; press_at = cyc; end
      if (RELEASE_PULSE === 1'b1) begin rel_n++;   rel_at   = cyc; end
      if (LONG_PULSE === 1'b1)    begin long_n++;  long_at  = cyc; end
      if (PRESS_PULSE && RELEASE_PULSE) excl_bad++;
      if (PRESS_PULSE && LONG_PULSE)    excl_bad++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   {31'd0, BTN_LEVEL},     32'd0);
    check({tag, "_press"},   {31'd0, PRESS_PULSE},   32'd0);
    check({tag, "_release"}, {31'd0, RELEASE_PULSE}, 32'd0);
    check({tag, "_long"},    {31'd0, LONG_PULSE},    32'd0);
    check({tag, "_count"},   {24'd0, PRESS_COUNT},   32'd0);
  endtask

  // One clean press of 12 cycles followed by a clean 12-cycle release.
  task automatic press_release();
    BTN = 1'b0;
    steps(12);
    BTN = 1'b1;
    steps(12);
  endtask

  initial begin
    // 1. Reset held with the button pressed.
    RST_N = 1'b0;
    BTN   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      steps(1);
      check_all_zero("rst_hold");
    end
    RST_N = 1'b1;
    mark();
    steps(14);
    check("rst_press_n",  press_n,  1);
    check("rst_press_at", press_at, 11);
    check("rst_level",    {31'd0, BTN_LEVEL}, 32'd1);
    check("rst_count",    {24'd0, PRESS_COUNT}, 32'd1);
    BTN = 1'b1;
    mark();
    steps(14);
    check("rst_rel_n",  rel_n,  1);
    check("rst_rel_at", rel_at, 11);
    check("rst_level0", {31'd0, BTN_LEVEL}, 32'd0);

    // 2. Clean press held 20 cycles, then clean release.
    mark();
    BTN = 1'b0;
    steps(20);
    check("clean_press_n",  press_n,  1);
    check("clean_press_at", press_at, 11);
    check("clean_level1",   {31'd0, BTN_LEVEL}, 32'd1);
    check("clean_count",    {24'd0, PRESS_COUNT}, 32'd2);
    check("clean_no_rel",   rel_n, 0);
    mark();
    BTN = 1'b1;
    steps(20);
    check("clean_rel_n",  rel_n,  1);
    check("clean_rel_at", rel_at, 11);
    check("clean_level0", {31'd0, BTN_LEVEL}, 32'd0);
    check("clean_no_press", press_n, 0);

    // 3a. Press bounce: low 5, high 3, low 5, then high.
    mark();
    BTN = 1'b0; steps(5);
    BTN = 1'b1; steps(3);
    BTN = 1'b0; steps(5);
    BTN = 1'b1; steps(20);
    check("bounce_press_n", press_n, 0);
    check("bounce_count",   {24'd0, PRESS_COUNT}, 32'd2);
    check("bounce_level",   {31'd0, BTN_LEVEL}, 32'd0);

    // 3b. Release bounce of 4 cycles while pressed.
    BTN = 1'b0;
    steps(12);
    check("rbounce_count", {24'd0, PRESS_COUNT}, 32'd3);
    mark();
    BTN = 1'b1; steps(4);
    BTN = 1'b0; steps(12);
    check("rbounce_rel_n", rel_n, 0);
    check("rbounce_level", {31'd0, BTN_LEVEL}, 32'd1);
    mark();
    BTN = 1'b1;
    steps(14);
    check("rbounce_final_rel", rel_n, 1);
    check("rbounce_level0",    {31'd0, BTN_LEVEL}, 32'd0);

    // 4. Long press: 60 cycles held.
    mark();
    BTN = 1'b0;
    steps(60);
    check("long_press_n",  press_n,  1);
    check("long_press_at", press_at, 11);
    check("long_n",        long_n,   LONG_EXP_N);
    check("long_at",       long_at,  LONG_EXP_AT);
    check("long_count",    {24'd0, PRESS_COUNT}, 32'd4);
    mark();
    BTN = 1'b1;
    steps(14);
    check("long_rel_n", rel_n, 1);
    check("long_no_long_after", long_n, 0);

    // 6. Reset in DB_PRESS with dcnt = 5 (8 cycles after the fall).
    mark();
    BTN = 1'b0;
    steps(8);
    RST_N = 1'b0;
    BTN   = 1'b1;
    steps(1);
    check_all_zero("midrst");
    steps(1);
    RST_N = 1'b1;
    steps(20);
    check("midrst_press_n", press_n, 0);
    check("midrst_count",   {24'd0, PRESS_COUNT}, 32'd0);
    check("midrst_level",   {31'd0, BTN_LEVEL}, 32'd0);
    mark();
    BTN = 1'b0;
    steps(14);
    check("midrst_restart_at",    press_at, 11);
    check("midrst_restart_count", {24'd0, PRESS_COUNT}, 32'd1);
    BTN = 1'b1;
    steps(14);
    RST_N = 1'b0;
    steps(2);
    check_all_zero("prewrap_rst");
    RST_N = 1'b1;
    steps(2);

    // 5. 256 clean presses wrap PRESS_COUNT back to 0.
    mark();
    for (int i = 0; i < 255; i++) press_release();
    check("wrap_count_ff", {24'd0, PRESS_COUNT}, 32'd255);
    press_release();
    check("wrap_count_0",  {24'd0, PRESS_COUNT}, 32'd0);
    check("wrap_press_n",  press_n, 256);
    check("wrap_rel_n",    rel_n,   256);
    check("wrap_long_n",   long_n,  0);

    check("pulse_exclusive", excl_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
